execute_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the execute stage, fed directly by the decode-execute pipeline register (operands, rd, M-extension op).
- Runs a fixed-latency radix-2 shift-add / restoring-divide sequence.
- Holds BusyE_o high so the hazard logic stalls fetch/decode and the decode-execute register.
- Returns a one-cycle result strobe with rd toward the execute-memory register.

---
 rtl/execute_muldiv_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Fixed 34-edge latency: one accept edge, 32 radix-2 steps, one sign-correct/output edge.
module execute_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ITERATIONS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartE_i,
  input  logic [2:0]            MulDivOpE_i,
  input  logic [DATA_WIDTH-1:0] OP1E_i,
  input  logic [DATA_WIDTH-1:0] OP2E_i,
  input  logic [4:0]            RdE_i,
  input  logic                  FlushE_i,
  output logic                  BusyE_o,
  output logic                  DoneE_o,
  output logic [DATA_WIDTH-1:0] ResultE_o,
  output logic [4:0]            RdOutE_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST_STEP = CW'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    oper_q, oper_d;     // multiplicand or divisor magnitude
  logic [2*W-1:0]  prod_q, prod_d;     // {accumulator/remainder, multiplier/dividend->quotient}
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [W-1:0]    result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            done_q, done_d;

  // Operand decode for a new request
  logic         op1_signed, op2_signed, s1, s2, start_div;
  logic [W-1:0] mag1, mag2;

  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (op_e'(MulDivOpE_i))
      OP_MULH, OP_DIV, OP_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      OP_MULHSU: op1_signed = 1'b1;
      default: ;
    endcase
    s1        = op1_signed & OP1E_i[W-1];
    s2        = op2_signed & OP2E_i[W-1];
    mag1      = s1 ? -OP1E_i : OP1E_i;
    mag2      = s2 ? -OP2E_i : OP2E_i;
    start_div = MulDivOpE_i[2];
  end

  // One radix-2 step of each algorithm; only the one matching op_q is used
  logic [W:0]     mul_sum, div_shift, div_trial;
  logic           div_ok;
  logic [2*W-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? oper_q : '0)};
    mul_next  = {mul_sum, prod_q[W-1:1]};
    div_shift = prod_q[2*W-1:W-1];
    div_trial = div_shift - {1'b0, oper_q};
    div_ok    = ~div_trial[W];
    div_next  = {(div_ok ? div_trial[W-1:0] : div_shift[W-1:0]), prod_q[W-2:0], div_ok};
  end

  // Sign correction and output selection
  logic [2*W-1:0] mul_full;
  logic [W-1:0]   quo_final, rem_final, finish_val;

  always_comb begin
    mul_full  = neg_res_q ? -prod_q : prod_q;
    quo_final = neg_res_q ? -prod_q[W-1:0] : prod_q[W-1:0];
    rem_final = neg_rem_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
    case (op_q)
      OP_MUL:                      finish_val = mul_full[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: finish_val = mul_full[2*W-1:W];
      OP_DIV, OP_DIVU:             finish_val = quo_final;
      default:                     finish_val = rem_final;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    oper_d    = oper_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (StartE_i && !FlushE_i) begin
          op_d      = op_e'(MulDivOpE_i);
          rd_d      = RdE_i;
          cnt_d     = '0;
          oper_d    = start_div ? mag2 : mag1;
          prod_d    = {{W{1'b0}}, (start_div ? mag1 : mag2)};
          // Divide-by-zero keeps the all-ones quotient unsigned
          neg_res_d = (s1 ^ s2) & ~(start_div & (OP2E_i == '0));
          neg_rem_d = s1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (FlushE_i) begin
          state_d = S_IDLE;
        end else begin
          prod_d = op_q[2] ? div_next : mul_next;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!FlushE_i) begin
          result_d = finish_val;
          rd_out_d = rd_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      cnt_q     <= '0;
      oper_q    <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      oper_q    <= oper_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      done_q    <= done_d;
    end
  end

  assign BusyE_o   = (state_q != S_IDLE);
  assign DoneE_o   = done_q;
  assign ResultE_o = result_q;
  assign RdOutE_o  = rd_out_q;

endmodule
